// File: rtl/rr_index_encoder.sv
// Round-robin request-to-index encoder for the 32-entry register file.
// Requests are gathered into a sticky pending set. One index is granted per
// valid/ready handshake, with a one-hot copy of the index and a registered
// count of the pending requests. This is the inverse of the register file's
// 5-to-32 one-hot address decode.
module rr_index_encoder #(
  parameter int N  = 32,
  parameter int W  = 5,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_in,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_idx,
  output logic [N-1:0]  out_onehot,
  output logic [CW-1:0] pend_count
);

  logic [N-1:0]  pending_q, pending_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_idx_q, out_idx_d;
  logic [N-1:0]  out_onehot_q, out_onehot_d;
  logic [CW-1:0] pend_count_q, pend_count_d;

  logic [W-1:0]  sel;
  logic          any;
  logic          load;
  logic [N-1:0]  sel_onehot;
  logic [N-1:0]  clr;

  // Number of set bits; CW is wide enough to hold N.
  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  // Rotating priority scan: first pending bit at or after ptr, wrapping at N.
  always_comb begin
    logic [W-1:0] idx;
    logic         found;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr_q + W'(i);
      if (!found && pending_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    any = |pending_q;
  end

  assign sel_onehot = N'(1) << sel;

  // Next-state: flush beats everything; otherwise load a new grant or hold on stall.
  always_comb begin
    load         = ~out_valid_q | out_ready;
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    ptr_d        = ptr_q;
    clr          = '0;
    pending_d    = pending_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      out_onehot_d = '0;
      pending_d    = '0;
    end else begin
      if (load) begin
        if (any) begin
          out_valid_d  = 1'b1;
          out_idx_d    = sel;
          out_onehot_d = sel_onehot;
          ptr_d        = sel + W'(1);
          clr          = sel_onehot;
        end else begin
          out_valid_d  = 1'b0;
          out_onehot_d = '0;
        end
      end
      // A same-cycle re-request of the granted bit keeps it pending.
      pending_d = (pending_q & ~clr) | req_in;
    end
    pend_count_d = popcount(pending_d);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q    <= '0;
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      pend_count_q <= '0;
    end else begin
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      pend_count_q <= pend_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign pend_count = pend_count_q;

endmodule

// File: tb/tb_rr_index_encoder.sv
// Directed bench for rr_index_encoder: a table of per-cycle inputs and the
// outputs expected right after that clock edge, plus a full-throughput sweep.
module tb_rr_index_encoder;

  localparam int N  = 32;
  localparam int W  = 5;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_in = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_idx;
  logic [N-1:0]  out_onehot;
  logic [CW-1:0] pend_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_index_encoder #(.N(N), .W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .pend_count (pend_count)
  );

  typedef struct {
    logic          rst_n;
    logic [N-1:0]  req;
    logic          flush;
    logic          ready;
    logic          v;
    logic [W-1:0]  idx;
    logic [N-1:0]  oh;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [N-1:0] q, input logic f,
                     input logic rd, input logic v, input logic [W-1:0] i,
                     input logic [N-1:0] oh, input logic [CW-1:0] c);
    vec_t t;
    t.rst_n = r; t.req = q; t.flush = f; t.ready = rd;
    t.v = v; t.idx = i; t.oh = oh; t.cnt = c;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] q, input logic f, input logic rd);
    @(negedge clk);
    rst_n = r; req_in = q; flush = f; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [W-1:0] i,
                            input logic [N-1:0] oh, input logic [CW-1:0] c);
    check({tag, ".valid"},  N'(out_valid),  N'(v));
    check({tag, ".idx"},    N'(out_idx),    N'(i));
    check({tag, ".onehot"}, out_onehot,     oh);
    check({tag, ".count"},  N'(pend_count), N'(c));
  endtask

  initial begin
    // rst req flush ready | valid idx onehot count
    // Reset, then single request to bit 0.
    add(0, 32'h0,        0, 0, 0, 0,  32'h0,        0);
    add(1, 32'h1,        0, 1, 0, 0,  32'h0,        1);
    add(1, 32'h0,        0, 1, 1, 0,  32'h1,        0);
    add(1, 32'h0,        0, 1, 0, 0,  32'h0,        0);
    // Reset, three requests in one cycle, wrap 31 -> 0.
    add(0, 32'h0,        0, 1, 0, 0,  32'h0,        0);
    add(1, 32'h80000005, 0, 1, 0, 0,  32'h0,        3);
    add(1, 32'h0,        0, 1, 1, 0,  32'h1,        2);
    add(1, 32'h0,        0, 1, 1, 2,  32'h4,        1);
    add(1, 32'h0,        0, 1, 1, 31, 32'h80000000, 0);
    add(1, 32'h0,        0, 1, 0, 31, 32'h0,        0);
    // Fairness: after granting 2 (ptr=3), bit 5 goes before bit 1.
    add(1, 32'h4,        0, 1, 0, 31, 32'h0,        1);
    add(1, 32'h22,       0, 1, 1, 2,  32'h4,        2);
    add(1, 32'h0,        0, 1, 1, 5,  32'h20,       1);
    add(1, 32'h0,        0, 1, 1, 1,  32'h2,        0);
    add(1, 32'h0,        0, 1, 0, 1,  32'h0,        0);
    // Stall with idx 4 held while bit 0 arrives.
    add(1, 32'h10,       0, 1, 0, 1,  32'h0,        1);
    add(1, 32'h0,        0, 0, 1, 4,  32'h10,       0);
    add(1, 32'h1,        0, 0, 1, 4,  32'h10,       1);
    add(1, 32'h0,        0, 0, 1, 4,  32'h10,       1);
    add(1, 32'h0,        0, 0, 1, 4,  32'h10,       1);
    add(1, 32'h0,        0, 1, 1, 0,  32'h1,        0);
    add(1, 32'h0,        0, 1, 0, 0,  32'h0,        0);
    // Continuous request on bit 7: set wins over the grant clear.
    add(1, 32'h80,       0, 1, 0, 0,  32'h0,        1);
    add(1, 32'h80,       0, 1, 1, 7,  32'h80,       1);
    add(1, 32'h80,       0, 1, 1, 7,  32'h80,       1);
    add(1, 32'h80,       0, 1, 1, 7,  32'h80,       1);
    add(1, 32'h0,        0, 1, 1, 7,  32'h80,       0);
    add(1, 32'h0,        0, 1, 0, 7,  32'h0,        0);
    // Flush with 3 pending and a valid grant; ptr must survive (ptr=1 after).
    add(1, 32'h7,        0, 0, 0, 7,  32'h0,        3);
    add(1, 32'h8,        0, 0, 1, 0,  32'h1,        3);
    add(1, 32'h200,      1, 1, 0, 0,  32'h0,        0);
    add(1, 32'h3,        0, 1, 0, 0,  32'h0,        2);
    add(1, 32'h0,        0, 1, 1, 1,  32'h2,        1);
    add(1, 32'h0,        0, 1, 1, 0,  32'h1,        0);
    add(1, 32'h0,        0, 1, 0, 0,  32'h0,        0);
    // Reset mid-stall: grant dropped, ptr back to 0 (bit 1 before bit 31).
    add(1, 32'h100,      0, 0, 0, 0,  32'h0,        1);
    add(1, 32'h3,        0, 0, 1, 8,  32'h100,      2);
    add(1, 32'h0,        0, 0, 1, 8,  32'h100,      2);
    add(0, 32'h0,        0, 0, 0, 0,  32'h0,        0);
    add(1, 32'h80000002, 0, 1, 0, 0,  32'h0,        2);
    add(1, 32'h0,        0, 1, 1, 1,  32'h2,        1);
    add(1, 32'h0,        0, 1, 1, 31, 32'h80000000, 0);
    add(1, 32'h0,        0, 1, 0, 31, 32'h0,        0);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst_n, vecs[k].req, vecs[k].flush, vecs[k].ready);
      expect_out($sformatf("vec%0d", k), vecs[k].v, vecs[k].idx, vecs[k].oh, vecs[k].cnt);
    end

    // Full-throughput sweep: every bit requested at once, ptr is 0 after the
    // last table grant of 31. Expect indices 0..31 on consecutive cycles.
    step(1, '1, 0, 1);
    expect_out("all.load", 0, 31, '0, 6'd32);
    for (int i = 0; i < N; i++) begin
      step(1, '0, 0, 1);
      expect_out($sformatf("all.g%0d", i), 1, W'(i), N'(1) << i, CW'(N - 1 - i));
    end
    step(1, '0, 0, 1);
    expect_out("all.idle", 0, 31, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
